reg_select_sequencer: RTL
=========================

Name: reg_select_sequencer

Overview:
- Sequencer that owns write access to the 16-entry GSU register file (r00–r15).
- Decodes prefix opcodes (TO/FROM/WITH/ALT1-3) and holds Sreg/Dreg/B/ALT state.
- Collects IBT/IWT immediate bytes, executes MOVE/MOVES, and schedules ALU write-back.
- Drives the file's z/zsel write path through a single registered strobe, z_wr; the integrator gates zsel with z_wr.

Parameters:
- DEFAULT_REG, 0, register index loaded into sreg/dreg at reset and at end of every instruction.
- IBT_SIGN_EXT, 1, 1: IBT byte is sign-extended to 16 bits; 0: zero-extended.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  opcode/operand byte present this cycle (always accepted).
- opcode  in  8  fetched byte.
- alu_wr  in  1  single-cycle ALU result for the non-prefix opcode presented this cycle.
- alu_data  in  16  ALU result.
- rd_data  in  16  register file read data for rd_sel (combinational).
- rd_sel  out  4  read index, used by MOVE/MOVES.
- sreg  out  4  current source register index.
- dreg  out  4  current destination register index.
- b_flag  out  1  WITH prefix active.
- alt  out  2  ALT mode.
- busy  out  1  immediate collection in progress; ALU must not decode.
- z  out  16  write data to register file.
- zsel  out  4  write index.
- z_wr  out  1  write strobe, one cycle.

Behaviour:
- Reset (async, reset=0): sreg=dreg=DEFAULT_REG, b_flag=0, alt=0, z=0, zsel=0, z_wr=0, busy=0, state=DECODE. Any partial immediate is discarded and no write is issued.
- States:
  - DECODE
  - IMM_LO (target t, kind IBT/IWT)
  - IMM_HI (target t, low byte latched)
- z_wr is registered: asserted on the edge after the accepting cycle, for exactly 1 cycle. z/zsel are valid with it and held afterwards. Default z_wr=0.
- "End-of-instruction" (EOI) means sreg=dreg=DEFAULT_REG, b_flag=0, alt=0 at the next edge.
- DECODE with op_valid, decode priority as listed:
  - 0x3D/0x3E/0x3F: alt=01/10/11. Other state unchanged.
  - 0x20+n (WITH): sreg=dreg=n, b_flag=1.
  - 0x10+n (TO):
    - b_flag=0: dreg=n.
    - b_flag=1 (MOVE): rd_sel=sreg combinationally; write Rn<=rd_data; EOI.
  - 0xB0+n (FROM):
    - b_flag=0: sreg=n.
    - b_flag=1 (MOVES): rd_sel=n; write R[dreg]<=rd_data; EOI.
  - 0xA0+n with alt=00 (IBT): go IMM_LO, t=n, busy=1.
  - 0xF0+n with alt=00 (IWT): go IMM_LO, t=n, busy=1.
  - 0xA0–0xAF or 0xF0–0xFF with alt≠00: non-prefix (memory op).
  - Any other opcode: non-prefix. If alu_wr=1, write R[dreg]<=alu_data. EOI regardless of alu_wr.
- IMM_LO with op_valid:
  - IBT: write R[t]<=ext(byte); EOI; busy=0; DECODE.
  - IWT: latch low byte; go IMM_HI.
- IMM_HI with op_valid: write R[t]<={byte,low}; EOI; busy=0; DECODE.
- op_valid=0 in any state: hold state. Stalls are unbounded.
- alu_wr is ignored in IMM states and with prefix opcodes.
- Prefix bytes do not disturb each other except as stated. Example: ALT1 then TO keeps alt.
- Writes to index 15 are issued normally; r15 arbitration lives in the register file.
- rd_sel defaults to sreg when not executing MOVES.

Test Plan:
- Reset mid-IWT: send 0xF3, 0x34, then drop reset → no z_wr; after release busy=0, sreg=dreg=0, state DECODE.
- IWT R3: 0xF3, 0x34, 0x12 → busy high for 2 bytes; z_wr 1 cycle after third byte with zsel=3, z=0x1234; then dreg=0.
- IBT sign extension: 0xA5, 0x80 → zsel=5, z=0xFF80. With IBT_SIGN_EXT=0 → z=0x0080.
- MOVE: 0x27 then 0x1A, rd_data=0xBEEF → rd_sel=7 during 0x1A; z_wr with zsel=10, z=0xBEEF; b_flag=0 after.
- MOVES: 0x22 then 0xB9, rd_data=0x8001 → rd_sel=9; zsel=2, z=0x8001.
- ALU write-back + ALT gating: 0x3D, 0x14, then non-prefix opcode 0x50 with alu_wr=1, alu_data=0x00FF → zsel=4, z=0x00FF; alt=00 after. Separately 0x3E, 0xF1 → no IMM state entered, busy stays 0.

Source files
------------

// File: rtl/reg_select_sequencer.sv
// Prefix/immediate sequencer owning the GSU register-file write port.
// Tracks Sreg/Dreg/B/ALT, collects IBT/IWT bytes and issues one registered write strobe per instruction.
module reg_select_sequencer #(
  parameter logic [3:0] DEFAULT_REG  = 4'd0,
  parameter bit         IBT_SIGN_EXT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [7:0]  opcode,
  input  logic        alu_wr,
  input  logic [15:0] alu_data,
  input  logic [15:0] rd_data,
  output logic [3:0]  rd_sel,
  output logic [3:0]  sreg,
  output logic [3:0]  dreg,
  output logic        b_flag,
  output logic [1:0]  alt,
  output logic        busy,
  output logic [15:0] z,
  output logic [3:0]  zsel,
  output logic        z_wr
);

  typedef enum logic [1:0] {
    DECODE = 2'd0,
    IMM_LO = 2'd1,
    IMM_HI = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  sreg_q, sreg_d;
  logic [3:0]  dreg_q, dreg_d;
  logic        b_flag_q, b_flag_d;
  logic [1:0]  alt_q, alt_d;
  logic        busy_q, busy_d;
  logic [15:0] z_q, z_d;
  logic [3:0]  zsel_q, zsel_d;
  logic        z_wr_q, z_wr_d;
  logic [3:0]  tgt_q, tgt_d;
  logic        iwt_q, iwt_d;
  logic [7:0]  low_q, low_d;
  logic        eoi;

  logic [3:0] op_hi, op_lo;
  assign op_hi = opcode[7:4];
  assign op_lo = opcode[3:0];

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    dreg_d   = dreg_q;
    b_flag_d = b_flag_q;
    alt_d    = alt_q;
    busy_d   = busy_q;
    z_d      = z_q;
    zsel_d   = zsel_q;
    z_wr_d   = 1'b0;
    tgt_d    = tgt_q;
    iwt_d    = iwt_q;
    low_d    = low_q;
    rd_sel   = sreg_q;
    eoi      = 1'b0;

    if (op_valid) begin
      case (state_q)
        DECODE: begin
          if (opcode == 8'h3D || opcode == 8'h3E || opcode == 8'h3F) begin
            alt_d = opcode[1:0];
          end else if (op_hi == 4'h2) begin
            sreg_d   = op_lo;
            dreg_d   = op_lo;
            b_flag_d = 1'b1;
          end else if (op_hi == 4'h1) begin
            if (b_flag_q) begin
              z_d    = rd_data;
              zsel_d = op_lo;
              z_wr_d = 1'b1;
              eoi    = 1'b1;
            end else begin
              dreg_d = op_lo;
            end
          end else if (op_hi == 4'hB) begin
            if (b_flag_q) begin
              rd_sel = op_lo;
              z_d    = rd_data;
              zsel_d = dreg_q;
              z_wr_d = 1'b1;
              eoi    = 1'b1;
            end else begin
              sreg_d = op_lo;
            end
          end else if ((op_hi == 4'hA || op_hi == 4'hF) && alt_q == 2'b00) begin
            state_d = IMM_LO;
            tgt_d   = op_lo;
            iwt_d   = (op_hi == 4'hF);
            busy_d  = 1'b1;
          end else begin
            // Non-prefix opcode (including ALT-qualified A/F memory ops)
            if (alu_wr) begin
              z_d    = alu_data;
              zsel_d = dreg_q;
              z_wr_d = 1'b1;
            end
            eoi = 1'b1;
          end
        end
        IMM_LO: begin
          if (iwt_q) begin
            low_d   = opcode;
            state_d = IMM_HI;
          end else begin
            z_d     = IBT_SIGN_EXT ? {{8{opcode[7]}}, opcode} : {8'h00, opcode};
            zsel_d  = tgt_q;
            z_wr_d  = 1'b1;
            eoi     = 1'b1;
            busy_d  = 1'b0;
            state_d = DECODE;
          end
        end
        IMM_HI: begin
          z_d     = {opcode, low_q};
          zsel_d  = tgt_q;
          z_wr_d  = 1'b1;
          eoi     = 1'b1;
          busy_d  = 1'b0;
          state_d = DECODE;
        end
        default: begin
          state_d = DECODE;
          busy_d  = 1'b0;
        end
      endcase
    end

    if (eoi) begin
      sreg_d   = DEFAULT_REG;
      dreg_d   = DEFAULT_REG;
      b_flag_d = 1'b0;
      alt_d    = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DECODE;
      sreg_q   <= DEFAULT_REG;
      dreg_q   <= DEFAULT_REG;
      b_flag_q <= 1'b0;
      alt_q    <= 2'b00;
      busy_q   <= 1'b0;
      z_q      <= 16'h0000;
      zsel_q   <= 4'h0;
      z_wr_q   <= 1'b0;
      tgt_q    <= 4'h0;
      iwt_q    <= 1'b0;
      low_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      dreg_q   <= dreg_d;
      b_flag_q <= b_flag_d;
      alt_q    <= alt_d;
      busy_q   <= busy_d;
      z_q      <= z_d;
      zsel_q   <= zsel_d;
      z_wr_q   <= z_wr_d;
      tgt_q    <= tgt_d;
      iwt_q    <= iwt_d;
      low_q    <= low_d;
    end
  end

  assign sreg   = sreg_q;
  assign dreg   = dreg_q;
  assign b_flag = b_flag_q;
  assign alt    = alt_q;
  assign busy   = busy_q;
  assign z      = z_q;
  assign zsel   = zsel_q;
  assign z_wr   = z_wr_q;

endmodule
